// File: rtl/mem_pkg.sv
// Shared encodings and lane-steering helpers for the MIPS-32 data memory
// and its load/store front end.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic {ST_CLEAR, ST_READY} state_e;

   // Byte-lane write enables for a store of the given size at byte offset off.
   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 4'b0001 << off;
         SZ_HALF: return 4'b0011 << {off[1], 1'b0};
         SZ_WORD: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Right-aligned store data replicated so every candidate lane carries it.
   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_BYTE: return {4{wdata[7:0]}};
         SZ_HALF: return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off);
      return word >> {off, 3'b000};
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] lanes, input logic [1:0] size,
                                          input logic uns);
      case (size)
         SZ_BYTE: return uns ? {24'h0, lanes[7:0]}  : {{24{lanes[7]}}, lanes[7:0]};
         SZ_HALF: return uns ? {16'h0, lanes[15:0]} : {{16{lanes[15]}}, lanes[15:0]};
         default: return lanes;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bram.sv
// DEPTH x 32 single-port RAM with per-byte write enables and a registered
// read port; maps onto block RAM.
module dmem_bram #(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] addr,
   input  logic [3:0]       we,
   input  logic [31:0]      wdata,
   input  logic             re,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH];

   // NOTE: no reset on the array or read register so this infers block RAM;
   // NOTE: sequential state always uses <= so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit plus data RAM for the MEM stage: size/alignment/range
// checks, byte-lane steering, post-reset clear and one-cycle responses.
module data_mem_lsu #(
   parameter int DEPTH          = 256,
   parameter int ADDR_WIDTH     = 32,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  init_done
);
   import mem_pkg::*;

   localparam int IDX_W = $clog2(DEPTH);

   state_e           state, state_next;
   logic [IDX_W-1:0] clr_idx;
   logic             accept, size_err, range_err, err;
   logic [IDX_W-1:0] ram_addr;
   logic [3:0]       ram_we;
   logic [31:0]      ram_wdata, ram_rdata;
   logic             ram_re;
   logic             p_load, p_uns;
   logic [1:0]       p_off, p_size;

   assign req_ready = (state == ST_READY);
   assign accept    = req_valid && req_ready;
   assign size_err  = (req_size == SZ_RSVD)
                   || (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
   assign range_err = req_addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH);
   assign err       = size_err || range_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clr_idx <= '0;
      end else begin
         state <= state_next;
         if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
      end
   end

   always_comb begin
      // NOTE: default first so no path leaves state_next unassigned (no latch).
      state_next = state;
      if (state == ST_CLEAR && clr_idx == IDX_W'(DEPTH - 1)) state_next = ST_READY;
   end

   // RAM port steering: the clear sweep owns the port until READY; writes are
   // suppressed while reset is sampled so a coincident store is discarded.
   always_comb begin
      ram_addr  = req_addr[IDX_W+1:2];
      ram_wdata = store_lanes(req_size, req_wdata);
      ram_we    = 4'b0000;
      ram_re    = 1'b0;
      if (state == ST_CLEAR) begin
         ram_addr  = clr_idx;
         ram_wdata = '0;
         ram_we    = 4'b1111;
      end else if (accept && !err) begin
         if (req_write) ram_we = store_be(req_size, req_addr[1:0]);
         else           ram_re = 1'b1;
      end
      if (!rst_n) ram_we = 4'b0000;
   end

   dmem_bram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (ram_wdata),
      .re    (ram_re),
      .rdata (ram_rdata)
   );

   // Response context only changes on acceptance, so rdata/err hold between pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         init_done <= 1'b0;
         p_load    <= 1'b0;
         p_uns     <= 1'b0;
         p_off     <= 2'b00;
         p_size    <= SZ_WORD;
      end else begin
         rsp_valid <= accept;
         init_done <= (state_next == ST_READY);
         if (accept) begin
            rsp_err <= err;
            p_load  <= !req_write && !err;
            p_uns   <= req_unsigned;
            p_off   <= req_addr[1:0];
            p_size  <= req_size;
         end
      end
   end

   assign rsp_rdata = p_load ? extend(lane_extract(ram_rdata, p_off), p_size, p_uns) : 32'h0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu (DEPTH=16) with a byte-array reference model
// compared against the DUT on every falling edge.
module tb_data_mem_lsu;
   import mem_pkg::*;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err, init_done;
   logic [31:0] rsp_rdata;

   int n_cmp = 0, n_bad = 0, n_pulse = 0;

   // Reference model state: byte-addressed memory, cycles since reset, expected outputs.
   bit          started = 1'b0;
   int          m_cyc = 0;
   logic        e_v = 1'b0, e_err = 1'b0;
   logic [31:0] e_rd = '0;
   logic [7:0]  mb [4*DEPTH];

   always #5 clk = ~clk;

   data_mem_lsu #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .init_done    (init_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_access();
      logic [31:0] a, v;
      logic        bad;
      int          nb;
      a   = req_addr;
      nb  = 1 << req_size;
      bad = (req_size == 2'b11) || (req_size == SZ_HALF && (a % 2) != 0)
         || (req_size == SZ_WORD && (a % 4) != 0) || ((a / 4) >= DEPTH);
      e_v   = 1'b1;
      e_err = bad;
      e_rd  = '0;
      if (!bad) begin
         if (req_write) begin
            for (int i = 0; i < nb; i++) mb[a+i] = req_wdata[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v |= 32'(mb[a+i]) << (8*i);
            if (!req_unsigned && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8*nb)) - 1);
            e_rd = v;
         end
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         started = 1'b1;
         m_cyc   = 0;
         e_v     = 1'b0;
         e_err   = 1'b0;
         e_rd    = '0;
         for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
      end else if (started) begin
         if (req_valid && m_cyc >= DEPTH) model_access();
         else e_v = 1'b0;
         if (m_cyc < DEPTH) m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("req_ready", req_ready, m_cyc >= DEPTH);
         check("init_done", init_done, m_cyc >= DEPTH);
         check("rsp_valid", rsp_valid, e_v);
         check("rsp_err",   rsp_err,   e_err);
         check("rsp_rdata", rsp_rdata, e_rd);
         if (rsp_valid) n_pulse++;
      end
   end

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input string name);
      issue(w, sz, u, a, d);
      @(negedge clk);
      check({name, "_rdata"}, rsp_rdata, exp_rd);
      check({name, "_err"},   rsp_err,   32'(exp_err));
      @(posedge clk); #1;
   endtask

   task automatic do_reset(output int lat);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      req_valid = 1'b0;
      check("rst_rsp_valid", rsp_valid, 0);
      lat = 0;
      while (!req_ready && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, p0;

      do_reset(lat);
      check("clear_latency", lat, 16);
      check("init_done_at_ready", init_done, 1);
      xact(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "lw0_after_clear");

      xact(1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, "sw8");
      xact(1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0, 32'hFFFFFFBE, 1'b0, "lb9");
      xact(1'b0, SZ_BYTE, 1'b1, 32'hA, 32'h0, 32'h000000AD, 1'b0, "lbua");
      xact(1'b0, SZ_HALF, 1'b0, 32'hA, 32'h0, 32'hFFFFDEAD, 1'b0, "lha");

      xact(1'b1, SZ_WORD, 1'b0, 32'h0, 32'h11223344, 32'h0, 1'b0, "sw0");
      xact(1'b1, SZ_BYTE, 1'b0, 32'h0, 32'h0000005A, 32'h0, 1'b0, "sb0");
      xact(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h1122335A, 1'b0, "lw0");

      issue(1'b1, SZ_WORD, 1'b0, 32'h4, 32'h11223344);
      issue(1'b1, SZ_BYTE, 1'b0, 32'h4, 32'h0000005A);
      issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
      @(negedge clk);
      check("b2b_lw4", rsp_rdata, 32'h1122335A);
      @(posedge clk); #1;

      xact(1'b0, SZ_WORD, 1'b0, 32'h6,       32'h0,        32'h0, 1'b1, "err_lw6");
      xact(1'b1, SZ_HALF, 1'b0, 32'h3,       32'h0000FFFF, 32'h0, 1'b1, "err_sh3");
      xact(1'b1, 2'b11,   1'b0, 32'h0,       32'hFFFFFFFF, 32'h0, 1'b1, "err_size3");
      xact(1'b0, SZ_WORD, 1'b0, 32'(4*DEPTH), 32'h0,       32'h0, 1'b1, "err_range");
      xact(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h1122335A, 1'b0, "lw0_unchanged");
      xact(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'h1122335A, 1'b0, "lw4_unchanged");

      p0 = n_pulse;
      issue(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h00000081);
      issue(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0);
      issue(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000BEEF);
      issue(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0);
      issue(1'b1, SZ_WORD, 1'b0, 32'h14, 32'hCAFEF00D);
      issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
      issue(1'b0, SZ_WORD, 1'b0, 32'h6,  32'h0);
      issue(1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("stream_pulses", n_pulse - p0, 8);
      xact(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 32'hFFFFFF81, 1'b0, "lb10");
      xact(1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0, 32'hFFFFCAFE, 1'b0, "lh16");

      req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
      req_addr  = 32'h8;
      do_reset(lat);
      check("clear_latency_rerun", lat, 16);
      xact(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, "lw8_cleared");
      xact(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "lw0_cleared");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised, synchronous data memory with an integrated load/store front end for the MIPS-32 datapath, sitting between the MEM pipeline stage and a word-organised RAM. It handles byte, halfword and word accesses: store byte-lane enables, load sign or zero extension, and alignment and range checking. It uses a valid/ready request handshake with one-cycle registered responses, and clears the whole array to zero after reset before accepting traffic.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥4.
- `ADDR_WIDTH`, 32: byte-address width.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill the array after reset; 0 = ready on the first cycle after reset.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle pulse per accepted request.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  request was rejected; valid only with `rsp_valid`.
- `init_done`  out  1  high once the clear sequence has finished.

## Operation
- Byte order is little-endian: byte lane k holds bits [8k+7:8k]. Word index is `req_addr[ADDR_WIDTH-1:2]`.
- FSM states:
  - CLEAR: `clr_idx` counts 0..DEPTH-1 and writes 0 to `mem[clr_idx]` each cycle. `req_ready`=0.
  - READY: `req_ready`=1.
  - Transitions: CLEAR→READY on the cycle `clr_idx`==DEPTH-1 is written. With `CLEAR_ON_RESET`=0, reset goes directly to READY. READY is left only by reset.
- A request is accepted when `req_valid` && `req_ready`.
- A request is an error if any of the following holds:
  - `req_size`==11;
  - half access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0;
  - word index ≥ DEPTH.
- An error request writes nothing and returns `rsp_err`=1 with `rsp_rdata`=0.
- Store:
  - Byte: lane `addr[1:0]` receives `wdata[7:0]`.
  - Half: lanes {`addr[1]`*2+1, `addr[1]`*2} receive `wdata[15:0]`.
  - Word: all four lanes.
  - Unselected lanes keep their contents.
  - Response: `rsp_rdata`=0, `rsp_err`=0.
- Load: the selected lane(s) are extracted and shifted to bit 0, then extended to 32 bits per `req_unsigned`. Word loads ignore `req_unsigned`.
- There is no response back-pressure; the consumer must take `rsp_*` on the `rsp_valid` cycle.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state = CLEAR (or READY when `CLEAR_ON_RESET`=0);
  - `clr_idx`=0;
  - `req_ready`=0 (1 when `CLEAR_ON_RESET`=0, from the first cycle after reset);
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `init_done`=0.
- Array contents are not reset directly; the clear sequence handles zeroing.
- Clear takes exactly DEPTH cycles. `req_ready` and `init_done` rise together in cycle DEPTH after reset release (cycle 0 being the first cycle with `rst_n`=1).
- Latency and throughput:
  - A request accepted in cycle N produces `rsp_valid`=1 in cycle N+1 only.
  - A store's RAM write commits at the end of cycle N.
  - Throughput is one request per cycle.
- Store in cycle N followed by a load to the same word in N+1 returns the new data; no forwarding is needed.
- Reset mid-operation:
  - Any response due next cycle is dropped (`rsp_valid`=0).
  - A store accepted in the same cycle reset is sampled is discarded.
  - The clear sequence restarts from index 0.
- `rsp_rdata` and `rsp_err` hold their last values while `rsp_valid`=0.

## Structure
- Shared package `mem_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the FSM state enum {`ST_CLEAR`, `ST_READY`};
  - lane-extract and extend helper functions.
- Sub-module `dmem_bram`:
  - `DEPTH`×32 array with 4-bit byte write enable and synchronous read;
  - no reset.
- The top level holds the FSM, clear counter, checks, lane steering and response registers.

## Test plan
- Reset then release, `DEPTH`=16: `req_ready`=0 for cycles 0–15, then 1 at cycle 16 together with `init_done`=1; a word load of 0x0 afterwards returns 0.
- Word store 0x8 = 0xDEADBEEF, then byte loads:
  - 0x9 signed → 0xFFFFFFBE;
  - 0xA unsigned → 0x000000AD;
  - half load 0xA signed → 0xFFFFDEAD.
- Byte store 0x0 = 0x5A over word 0x11223344, then word load → 0x1122335A; back-to-back store/load on consecutive cycles gives the same result.
- Errors (each must return `rsp_err`=1, `rsp_rdata`=0, and leave memory unchanged):
  - word load at 0x6;
  - half store at 0x3;
  - `req_size`=11;
  - address 4*DEPTH.
- Stream 8 mixed requests, one per cycle, with `req_valid` held high: exactly 8 `rsp_valid` pulses, each one cycle after its request.
- Assert `rst_n`=0 for one cycle while a load is in flight: no `rsp_valid`; the clear sequence reruns and previously written data reads as 0.
